if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_pkg.sv | 11 +
 rtl/fetch_queue.sv | 54 +++++
 rtl/if_stage.sv | 84 ++++++++
 tb/tb_if_stage.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared CPU front-end types: the fetch-queue entry layout and the instruction-memory address width.
package if_stage_pkg;

  localparam int IADDR_W = 14;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small circular FIFO of fetched {pc, instr} entries with synchronous flush.
// The head entry is presented combinationally.
module fetch_queue
  import if_stage_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty,
  output logic [CW-1:0] count
);

  fetch_entry_t mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset; stale slots are never visible because count is cleared.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  assert property (@(posedge clk) disable iff (rst || flush) !(push && full && !pop));
  assert property (@(posedge clk) disable iff (rst || flush) !(pop && empty));

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: issues one word read per cycle while the queue has room,
// queues responses for decode, and restarts cleanly on a control-flow redirect.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int          QDEPTH   = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               im_en,
  output logic [IADDR_W-1:0] im_addr,
  input  logic [31:0]        im_rdata,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [31:0]        id_pc,
  output logic [31:0]        id_instr
);

  localparam int CW = $clog2(QDEPTH + 1);
  localparam int PW = CW + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   inflight_pc;
  logic          inflight;
  logic [CW-1:0] occupancy;
  logic          q_full;
  logic          q_empty;
  logic          pop;
  logic          push;
  logic [PW-1:0] pending;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;

  // An issue is allowed only if the entry it produces is guaranteed a slot next cycle.
  always_comb begin
    id_valid   = !q_empty && !redirect_valid && !rst;
    pop        = id_valid && id_ready;
    pending    = PW'(occupancy) + PW'(inflight) - PW'(pop);
    im_en      = !rst && !redirect_valid && (pending < PW'(QDEPTH));
    push       = inflight && !redirect_valid && !rst;
    push_entry = '{pc: inflight_pc, instr: im_rdata};
  end

  assign im_addr  = fetch_pc[IADDR_W+1:2];
  assign id_pc    = head.pc;
  assign id_instr = head.instr;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
      inflight <= 1'b0;
    end else begin
      inflight <= im_en;
      if (im_en) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 32'd4;
      end
    end
  end

  fetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (occupancy)
  );

  // Queued entries plus the outstanding read can never exceed the queue depth.
  assert property (@(posedge clk) disable iff (rst) !(q_full && inflight));

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: issued PCs are queued by a reference model and
// matched against what decode sees, with directed redirect/wrap/reset scenarios.
module tb_if_stage;
  import if_stage_pkg::*;

  localparam int          QDEPTH   = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic               clk;
  logic               rst;
  logic               redirect_valid;
  logic [31:0]        redirect_pc;
  logic               im_en;
  logic [IADDR_W-1:0] im_addr;
  logic [31:0]        im_rdata;
  logic               id_valid;
  logic               id_ready;
  logic [31:0]        id_pc;
  logic [31:0]        id_instr;

  int checks;
  int errors;
  int deliveries;
  int d0;

  logic [31:0] sb[$];
  logic [31:0] model_pc;
  logic        model_inflight;
  int          exp_occ;
  logic        exp_valid;
  logic        exp_pop;
  logic        exp_im_en;

  if_stage #(.QDEPTH(QDEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .im_en          (im_en),
    .im_addr        (im_addr),
    .im_rdata       (im_rdata),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_pc          (id_pc),
    .id_instr       (id_instr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [13:0] a);
    return {2'b10, a, ~a, 2'b01};
  endfunction

  // Instruction memory: one-cycle read latency.
  always @(posedge clk) begin
    if (im_en) im_rdata <= mem_word(im_addr);
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic rv, input logic [31:0] rpc,
                               input logic rdy, input int cycles);
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    id_ready       = rdy;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model, evaluated mid-cycle while inputs are stable.
  always @(negedge clk) begin
    if (rst) begin
      checkOutput("rst_im_en", {31'b0, im_en}, 32'd0);
      checkOutput("rst_id_valid", {31'b0, id_valid}, 32'd0);
      sb.delete();
      model_inflight = 1'b0;
      model_pc       = RESET_PC;
    end else if (redirect_valid) begin
      checkOutput("redir_im_en", {31'b0, im_en}, 32'd0);
      checkOutput("redir_id_valid", {31'b0, id_valid}, 32'd0);
      sb.delete();
      model_inflight = 1'b0;
      model_pc       = redirect_pc & 32'hFFFF_FFFC;
    end else begin
      exp_occ   = sb.size() - (model_inflight ? 1 : 0);
      exp_valid = (exp_occ != 0);
      exp_pop   = exp_valid && id_ready;
      exp_im_en = (sb.size() - (exp_pop ? 1 : 0)) < QDEPTH;
      checkOutput("id_valid", {31'b0, id_valid}, {31'b0, exp_valid});
      checkOutput("im_en", {31'b0, im_en}, {31'b0, exp_im_en});
      if (exp_valid) begin
        checkOutput("id_pc", id_pc, sb[0]);
        checkOutput("id_instr", id_instr, mem_word(sb[0][15:2]));
      end
      if (exp_pop) begin
        void'(sb.pop_front());
        deliveries++;
      end
      if (exp_im_en) begin
        checkOutput("im_addr", {18'b0, im_addr}, {18'b0, model_pc[15:2]});
        sb.push_back(model_pc);
        model_pc = model_pc + 32'd4;
      end
      model_inflight = exp_im_en;
    end
  end

  initial begin
    checks     = 0;
    errors     = 0;
    deliveries = 0;
    im_rdata   = '0;

    // Reset, then free-running decode: one instruction per cycle after the fill.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 3);
    d0 = deliveries;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 10);
    checkOutput("throughput", deliveries - d0, 32'd8);

    // Decode stalled: two entries queue up, the head is held, fetch stops.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 2);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 5);
    checkOutput("stall_valid", {31'b0, id_valid}, 32'd1);
    checkOutput("stall_head", id_pc, RESET_PC);
    checkOutput("stall_im_en", {31'b0, im_en}, 32'd0);
    d0 = deliveries;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 6);
    checkOutput("resume_count", deliveries - d0, 32'd6);

    // Redirect while the queue is busy and a read is outstanding.
    applyStimulus(1'b0, 1'b1, 32'h0000_0100, 1'b1, 1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 0);
    #1;
    checkOutput("redir_100_en", {31'b0, im_en}, 32'd1);
    checkOutput("redir_100_addr", {18'b0, im_addr}, 32'h040);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 6);

    // Unaligned redirect target is word-aligned.
    applyStimulus(1'b0, 1'b1, 32'h0000_0203, 1'b1, 1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 0);
    #1;
    checkOutput("redir_203_addr", {18'b0, im_addr}, 32'h080);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 5);

    // Fetch PC wraps past the top of the address space.
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 0);
    #1;
    checkOutput("wrap_addr_hi", {18'b0, im_addr}, 32'h3FFF);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1);
    checkOutput("wrap_addr_lo", {18'b0, im_addr}, 32'h0000);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 6);

    // Reset mid-operation with a full queue.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 3);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 0);
    #1;
    checkOutput("post_rst_valid", {31'b0, id_valid}, 32'd0);
    checkOutput("post_rst_en", {31'b0, im_en}, 32'd1);
    checkOutput("post_rst_addr", {18'b0, im_addr}, {18'b0, RESET_PC[15:2]});
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 6);

    // Random back-pressure with occasional redirects.
    for (int i = 0; i < 80; i++) begin
      applyStimulus(1'b0, ($urandom_range(0, 11) == 0), $urandom,
                    ($urandom_range(0, 3) != 0), 1);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
